// File: rtl/bist_fail_log_if.sv
// bist_fail_log_if: compare-strobe input, log readout handshake and status bundle
interface bist_fail_log_if #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int CW = 8
);
    logic          test_start;
    logic          test_active;
    logic          cmp_valid;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_exp;
    logic [DW-1:0] cmp_act;
    logic          rd_ready;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] rd_syn;
    logic [CW-1:0] fail_count;
    logic          overflow;
    logic          any_fail;
    logic          busy;
    logic          done;

    modport master (
        output test_start, test_active, cmp_valid, cmp_addr, cmp_exp, cmp_act, rd_ready,
        input  rd_valid, rd_addr, rd_exp, rd_syn, fail_count, overflow, any_fail, busy, done
    );

    modport slave (
        input  test_start, test_active, cmp_valid, cmp_addr, cmp_exp, cmp_act, rd_ready,
        output rd_valid, rd_addr, rd_exp, rd_syn, fail_count, overflow, any_fail, busy, done
    );
endinterface

// File: rtl/bist_fail_log.sv
// bist_fail_log: captures the first DEPTH BIST miscompares in order and holds them for readout
module bist_fail_log #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input logic clk,
    input logic rst,
    bist_fail_log_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int PL = PW + 1;
    localparam int EW = AW + 2 * DW;

    typedef enum logic [1:0] {IDLE, LOG, HOLD} state_t;

    state_t        state;
    logic [PW:0]   head;
    logic [PW:0]   tail;
    logic [CW-1:0] fail_count;
    logic          overflow;
    logic          seen_active;
    logic          done;
    logic [EW-1:0] mem [DEPTH];

    logic miscmp, full, empty, rd_valid, capture;

    assign miscmp   = bus.cmp_valid && bus.test_active && (bus.cmp_act != bus.cmp_exp);
    assign full     = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
    assign empty    = head == tail;
    assign rd_valid = (state == HOLD) && !empty;
    assign capture  = !bus.test_start && (state == LOG) && miscmp && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            fail_count  <= '0;
            overflow    <= 1'b0;
            seen_active <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.test_start) begin
                state       <= LOG;
                head        <= '0;
                tail        <= '0;
                fail_count  <= '0;
                overflow    <= 1'b0;
                seen_active <= 1'b0;
            end else if (state == LOG) begin
                if (bus.test_active)
                    seen_active <= 1'b1;
                if (miscmp) begin
                    if (fail_count != '1)
                        fail_count <= fail_count + CW'(1);
                    if (full)
                        overflow <= 1'b1;
                    else
                        tail <= tail + PL'(1);
                end
                if (seen_active && !bus.test_active) begin
                    state <= HOLD;
                    done  <= 1'b1;
                end
            end else if (state == HOLD && rd_valid && bus.rd_ready) begin
                head <= head + PL'(1);
            end
        end
    end

    // Log storage needs no reset: contents are only visible while rd_valid is high
    always_ff @(posedge clk)
        if (capture)
            mem[tail[PW-1:0]] <= {bus.cmp_addr, bus.cmp_exp, bus.cmp_exp ^ bus.cmp_act};

    assign {bus.rd_addr, bus.rd_exp, bus.rd_syn} = rd_valid ? mem[head[PW-1:0]] : '0;
    assign bus.rd_valid   = rd_valid;
    assign bus.fail_count = fail_count;
    assign bus.overflow   = overflow;
    assign bus.any_fail   = fail_count != '0;
    assign bus.busy       = state == LOG;
    assign bus.done       = done;
endmodule

// File: tb/tb_bist_fail_log.sv
// tb_bist_fail_log: scoreboard bench for the BIST fail-capture log
module tb_bist_fail_log;
    localparam int AW = 6, DW = 8, DEPTH = 4, CW = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        logic [DW-1:0] s;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    ent_t sb[$];
    int   m_cnt = 0;
    logic m_ov = 1'b0;

    bist_fail_log_if #(.AW(AW), .DW(DW), .CW(CW)) bif();
    bist_fail_log #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start;
        bif.test_start = 1'b1;
        tick();
        bif.test_start = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_ov  = 1'b0;
    endtask

    task automatic cmp(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic [DW-1:0] act);
        bif.cmp_valid = 1'b1;
        bif.cmp_addr  = a;
        bif.cmp_exp   = e;
        bif.cmp_act   = act;
        if (bif.test_active && e !== act) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            if (sb.size() < DEPTH) sb.push_back('{a, e, e ^ act});
            else m_ov = 1'b1;
        end
        tick();
        bif.cmp_valid = 1'b0;
    endtask

    task automatic run_begin;
        start();
        bif.test_active = 1'b1;
        tick();
    endtask

    task automatic run_end(input string n);
        bif.test_active = 1'b0;
        tick();
        checks++;
        if (bif.done !== 1'b1 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s end done=%0b busy=%0b want done=1 busy=0", n, bif.done, bif.busy);
        end
        checks++;
        if (bif.fail_count !== CW'(m_cnt) || bif.overflow !== m_ov || bif.any_fail !== (m_cnt != 0)) begin
            failures++;
            $display("FAIL %s status count=%0d ov=%0b any=%0b want count=%0d ov=%0b any=%0b",
                     n, bif.fail_count, bif.overflow, bif.any_fail, m_cnt, m_ov, m_cnt != 0);
        end
        tick();
        checks++;
        if (bif.done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse done=%0b want 0", n, bif.done);
        end
    endtask

    task automatic drain(input string n);
        ent_t got;
        bif.rd_ready = 1'b1;
        while (sb.size() > 0) begin
            got = {bif.rd_addr, bif.rd_exp, bif.rd_syn};
            checks++;
            if (bif.rd_valid !== 1'b1 || got !== sb[0]) begin
                failures++;
                $display("FAIL %s read valid=%0b got=%h want valid=1 %h", n, bif.rd_valid, got, sb[0]);
            end
            void'(sb.pop_front());
            tick();
        end
        bif.rd_ready = 1'b0;
        checks++;
        if (bif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s empty rd_valid=%0b want 0", n, bif.rd_valid);
        end
    endtask

    task automatic test_reset;
        tick();
        checks++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.fail_count !== '0 || bif.overflow !== 1'b0 || bif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%0b done=%0b cnt=%0d ov=%0b rv=%0b want all 0",
                     bif.busy, bif.done, bif.fail_count, bif.overflow, bif.rd_valid);
        end
        rst = 1'b0;
        run_begin();
        cmp(6'h01, 8'h0F, 8'h0E);
        checks++;
        if (bif.fail_count !== 8'd1 || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre count=%0d busy=%0b want 1 1", bif.fail_count, bif.busy);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bif.busy !== 1'b0 || bif.fail_count !== '0 || bif.any_fail !== 1'b0) begin
            failures++;
            $display("FAIL reset_async busy=%0b count=%0d any=%0b want 0 0 0", bif.busy, bif.fail_count, bif.any_fail);
        end
        bif.test_active = 1'b0;
        tick();
        #2 rst = 1'b0;
        bif.rd_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (bif.busy !== 1'b0 || bif.rd_valid !== 1'b0 || bif.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%0b rv=%0b done=%0b want 0 0 0", bif.busy, bif.rd_valid, bif.done);
        end
        bif.rd_ready = 1'b0;
    endtask

    task automatic test_clean;
        run_begin();
        for (int i = 0; i < 20; i++) cmp(AW'(i), DW'(i * 3), DW'(i * 3));
        run_end("clean");
        drain("clean");
    endtask

    task automatic test_two;
        run_begin();
        cmp(6'h05, 8'hAA, 8'hAB);
        tick();
        cmp(6'h3F, 8'h55, 8'h00);
        run_end("two");
        drain("two");
    endtask

    task automatic test_overflow;
        run_begin();
        for (int i = 0; i < 6; i++) cmp(AW'(i), DW'(8'h10 + i), ~DW'(8'h10 + i));
        run_end("overflow");
        drain("overflow");
    endtask

    task automatic test_saturation;
        start();
        cmp(6'h01, 8'h01, 8'h02);
        checks++;
        if (bif.busy !== 1'b1 || bif.fail_count !== '0) begin
            failures++;
            $display("FAIL gated busy=%0b count=%0d want 1 0", bif.busy, bif.fail_count);
        end
        bif.test_active = 1'b1;
        bif.rd_ready = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) cmp(AW'(i), DW'(i), ~DW'(i));
        bif.rd_ready = 1'b0;
        run_end("saturation");
        drain("saturation");
    endtask

    task automatic test_restart;
        run_begin();
        cmp(6'h21, 8'h11, 8'h10);
        cmp(6'h22, 8'h22, 8'h20);
        cmp(6'h23, 8'h33, 8'h30);
        run_end("restart");
        bif.rd_ready = 1'b1;
        tick();
        bif.rd_ready = 1'b0;
        void'(sb.pop_front());
        repeat (5) tick();
        checks++;
        if (bif.rd_valid !== 1'b1 || bif.rd_addr !== sb[0].a || bif.rd_exp !== sb[0].e || bif.rd_syn !== sb[0].s) begin
            failures++;
            $display("FAIL backpressure rv=%0b got=%h/%h/%h want %h/%h/%h", bif.rd_valid,
                     bif.rd_addr, bif.rd_exp, bif.rd_syn, sb[0].a, sb[0].e, sb[0].s);
        end
        bif.rd_ready = 1'b1;
        start();
        bif.rd_ready = 1'b0;
        checks++;
        if (bif.busy !== 1'b1 || bif.fail_count !== '0 || bif.any_fail !== 1'b0 || bif.overflow !== 1'b0 || bif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL restart busy=%0b count=%0d any=%0b ov=%0b rv=%0b want 1 0 0 0 0",
                     bif.busy, bif.fail_count, bif.any_fail, bif.overflow, bif.rd_valid);
        end
        bif.test_active = 1'b1;
        tick();
        run_end("restart_rerun");
        drain("restart_rerun");
    endtask

    initial begin
        bif.test_start  = 1'b0;
        bif.test_active = 1'b0;
        bif.cmp_valid   = 1'b0;
        bif.cmp_addr    = '0;
        bif.cmp_exp     = '0;
        bif.cmp_act     = '0;
        bif.rd_ready    = 1'b0;
        test_reset();
        test_clean();
        test_two();
        test_overflow();
        test_saturation();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
